pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter NUM_BALLS, 3: balls per game, legal range 1..3.
REQ-002 Parameter DELAY_TICKS, 120: frame ticks in each post-miss and game-over pause, which is 2 s at 60 Hz; legal range 1..127.
REQ-003 clk  in  1  system clock (pixel-domain clock shared with graphics).
REQ-004 reset  in  1  synchronous, active-high reset; one clock; sampled on rising clk edge.
REQ-005 btn  in  2  player buttons, btn[0]=up, btn[1]=down; "any button" = btn != 2'b00.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame (start of vertical retrace).
REQ-007 hit  in  1  level from graphics: ball overlaps paddle; may stay high many cycles.
REQ-008 miss  in  1  level from graphics: ball passed right screen edge.
REQ-009 gra_still  out  1  1 = graphics frozen, ball held at centre.
REQ-010 msg_sel  out  2  text overlay: 00 none, 01 "press to start", 10 "game over", 11 reserved/unused.
REQ-011 score_d1  out  4  score tens digit, BCD.
REQ-012 score_d0  out  4  score units digit, BCD.
REQ-013 balls_left  out  2  balls remaining after the one in play.
REQ-014 state  out  2  current FSM state code, for debug.

Function
REQ-015 FSM states and codes: NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11; state register updates only on rising clk.
REQ-016 gra_still is a Moore output: 0 in PLAY and 1 in all other states.
REQ-017 msg_sel is a Moore output: 01 in NEWGAME, 10 in OVER, and 00 in PLAY and NEWBALL.
REQ-018 NEWGAME behaviour: score held at 00; balls_left held at NUM_BALLS.
REQ-019 NEWGAME exit: on any button, go to PLAY next cycle and load balls_left = NUM_BALLS-1.
REQ-020 Hit edge detect: a registered copy of hit is kept; hit_rise = hit & ~hit_q.
REQ-021 Scoring: score increments by exactly 1 per hit_rise while in PLAY; a held hit level never increments more than once.
REQ-022 Score arithmetic: BCD; d0 9->0 carries into d1; the score wraps 99->00 and no digit ever holds a value above 9.
REQ-023 PLAY, miss=1 and balls_left=0: go to OVER and load the timer with DELAY_TICKS.
REQ-024 PLAY, miss=1 and balls_left>0: go to NEWBALL, decrement balls_left by 1 and load the timer with DELAY_TICKS.
REQ-025 Simultaneous hit_rise and miss in the same PLAY cycle: the score increments and the miss transition also occurs.
REQ-026 Timer is 7 bits: it decrements by 1 on each frame_tick while nonzero; timer_up = (timer == 0); a load takes priority over a decrement.
REQ-027 NEWBALL exit: when timer_up and any button are true together, go to PLAY; a button press before timer_up is ignored; no btn release is required.
REQ-028 OVER exit: on timer_up, go to NEWGAME; buttons are ignored in OVER.
REQ-029 Score is retained through NEWBALL and OVER; it is cleared on entry to NEWGAME (the cycle the state becomes NEWGAME).
REQ-030 hit and miss outside PLAY have no effect on score, balls_left or state; hit_q still tracks hit every cycle.
REQ-031 Latency: every transition takes effect on the first clk edge at which its condition is sampled true.

Reset
REQ-032 Reset forces state=NEWGAME, score=00, balls_left=NUM_BALLS, timer=0 and hit_q=0.
REQ-033 Reset takes priority over every other input on the same edge.
REQ-034 Reset asserted mid-PLAY, mid-NEWBALL or mid-OVER aborts the game fully with no residual timer or score.
REQ-035 Reset values on outputs: gra_still=1, msg_sel=01, score_d1=0, score_d0=0, balls_left=NUM_BALLS, state=00, beginning one cycle after reset is sampled.

Verification
REQ-036 Start: reset, then btn=01 for 1 cycle -> next cycle state=01, gra_still=0, balls_left=2.
REQ-037 Scoring: in PLAY, hit high for 500 cycles -> score=01; then 3 further single-cycle hit pulses -> score=04; 99 + one hit -> 00.
REQ-038 Ball loss: in PLAY with balls_left=2, miss pulse -> state=10, balls_left=1, gra_still=1; btn held while applying 119 frame_ticks -> stays 10; 120th tick -> timer_up, then next cycle state=01.
REQ-039 Game over: with balls_left=0, miss -> state=11 and msg_sel=10; after 120 frame_ticks -> state=00, and score reads 00 on NEWGAME entry.
REQ-040 Collision: hit rising and miss in the same cycle with balls_left=1 -> score +1, state=10, balls_left=0.
REQ-041 Reset during NEWBALL with timer=50 and score=07 -> next cycle state=00, score=00, balls_left=3, and outputs match REQ-035.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new-game / play / new-ball / game-over flow,
// BCD score keeping, ball accounting and the frame-tick pause timer.
module pong_game_ctrl #(
    parameter int NUM_BALLS   = 3,
    parameter int DELAY_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [1:0] msg_sel,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] balls_left,
    output logic [1:0] state
);

    // state   | meaning
    // NEWGAME | waiting for a button, "press to start" shown
    // PLAY    | ball in motion, hits score, misses cost a ball
    // NEWBALL | pause after a miss, button relaunches once timer expires
    // OVER    | "game over" pause, returns to NEWGAME on timer expiry
    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);
    localparam logic [6:0] DELAY      = 7'(DELAY_TICKS);

    state_t     state_q, state_d;
    logic [3:0] d1_q, d1_d;
    logic [3:0] d0_q, d0_d;
    logic [1:0] balls_q, balls_d;
    logic [6:0] timer_q, timer_d;
    logic       hit_q;
    logic       gra_still_q, gra_still_d;
    logic [1:0] msg_q, msg_d;

    logic any_btn;
    logic timer_up;
    logic hit_rise;

    assign any_btn  = (btn != 2'b00);
    assign timer_up = (timer_q == 7'd0);
    assign hit_rise = hit & ~hit_q;

    always_comb begin
        state_d = state_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        balls_d = balls_q;
        timer_d = timer_q;

        if (frame_tick && !timer_up) begin
            timer_d = timer_q - 7'd1;
        end

        case (state_q)
            NEWGAME: begin
                if (any_btn) begin
                    state_d = PLAY;
                    balls_d = BALLS_INIT - 2'd1;
                end
            end
            PLAY: begin
                if (hit_rise) begin
                    if (d0_q >= 4'd9) begin
                        d0_d = 4'd0;
                        d1_d = (d1_q >= 4'd9) ? 4'd0 : d1_q + 4'd1;
                    end else begin
                        d0_d = d0_q + 4'd1;
                    end
                end
                if (miss) begin
                    timer_d = DELAY;
                    if (balls_q == 2'd0) begin
                        state_d = OVER;
                    end else begin
                        state_d = NEWBALL;
                        balls_d = balls_q - 2'd1;
                    end
                end
            end
            NEWBALL: begin
                if (timer_up && any_btn) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (timer_up) begin
                    state_d = NEWGAME;
                end
            end
            default: state_d = NEWGAME;
        endcase

        // NEWGAME always shows a fresh score and a full ball count
        if (state_d == NEWGAME) begin
            d1_d    = 4'd0;
            d0_d    = 4'd0;
            balls_d = BALLS_INIT;
        end

        gra_still_d = (state_d != PLAY);
        case (state_d)
            NEWGAME: msg_d = 2'b01;
            OVER:    msg_d = 2'b10;
            default: msg_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= NEWGAME;
            d1_q        <= 4'd0;
            d0_q        <= 4'd0;
            balls_q     <= BALLS_INIT;
            timer_q     <= 7'd0;
            hit_q       <= 1'b0;
            gra_still_q <= 1'b1;
            msg_q       <= 2'b01;
        end else begin
            state_q     <= state_d;
            d1_q        <= d1_d;
            d0_q        <= d0_d;
            balls_q     <= balls_d;
            timer_q     <= timer_d;
            hit_q       <= hit;
            gra_still_q <= gra_still_d;
            msg_q       <= msg_d;
        end
    end

    assign gra_still  = gra_still_q;
    assign msg_sel    = msg_q;
    assign score_d1   = d1_q;
    assign score_d0   = d0_q;
    assign balls_left = balls_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table plus hand-written
// game sequences, expected outputs queued at drive time and popped after the edge.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [1:0] msg_sel;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
    logic [1:0] balls_left;
    logic [1:0] state;

    pong_game_ctrl #(.NUM_BALLS(3), .DELAY_TICKS(120)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .frame_tick (frame_tick),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .msg_sel    (msg_sel),
        .score_d1   (score_d1),
        .score_d0   (score_d0),
        .balls_left (balls_left),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       still;
        logic [1:0] msg;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [1:0] balls;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [1:0] btn;
        logic       tick;
        logic       hit;
        logic       miss;
        out_t       exp;
    } vec_t;

    out_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   sc = 0;

    localparam int S_NG = 0, S_PL = 1, S_NB = 2, S_OV = 3;

    // Expected output word for a given state, ball count and decimal score
    function automatic out_t o(input int st, input int b, input int n);
        out_t r;
        r.st    = 2'(st);
        r.still = (st != S_PL);
        r.msg   = (st == S_NG) ? 2'b01 : (st == S_OV) ? 2'b10 : 2'b00;
        r.d1    = 4'(n / 10);
        r.d0    = 4'(n % 10);
        r.balls = 2'(b);
        return r;
    endfunction

    task automatic drv(input logic r, input logic [1:0] b, input logic t,
                       input logic h, input logic m, input out_t e,
                       input string nm);
        out_t got;
        out_t ex;
        reset      = r;
        btn        = b;
        frame_tick = t;
        hit        = h;
        miss       = m;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {state, gra_still, msg_sel, score_d1, score_d0, balls_left};
        ex  = sb_q.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL %s: got st=%0d still=%0d msg=%0d score=%0d%0d balls=%0d, expected st=%0d still=%0d msg=%0d score=%0d%0d balls=%0d",
                     nm, got.st, got.still, got.msg, got.d1, got.d0, got.balls,
                     ex.st, ex.still, ex.msg, ex.d1, ex.d0, ex.balls);
        end
    endtask

    task automatic pulse(input int b, input string nm);
        sc = (sc + 1) % 100;
        drv(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, o(S_PL, b, sc), nm);
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, o(S_PL, b, sc), nm);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, o(S_NG, 3, 0)};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, o(S_NG, 3, 0)};
        tbl[2]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, o(S_NG, 3, 0)};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_PL, 2, 0)};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, o(S_PL, 2, 1)};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, o(S_PL, 2, 1)};
        tbl[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, o(S_PL, 2, 1)};
        tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, o(S_PL, 2, 2)};
        tbl[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, o(S_NB, 1, 2)};
        tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, o(S_NB, 1, 2)};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, o(S_NB, 1, 2)};

        for (int i = 0; i < 11; i++) begin
            drv(tbl[i].rst, tbl[i].btn, tbl[i].tick, tbl[i].hit, tbl[i].miss,
                tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Start and held-hit scoring, BCD carry and 99 -> 00 wrap
        drv(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, o(S_NG, 3, 0), "reset_again");
        drv(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_PL, 2, 0), "start");
        sc = 1;
        for (int k = 0; k < 500; k++)
            drv(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, o(S_PL, 2, 1), "held_hit");
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, o(S_PL, 2, 1), "hit_release");
        for (int k = 0; k < 3; k++) pulse(2, "pulse_to_4");
        while (sc != 99) pulse(2, "pulse_to_99");
        pulse(2, "wrap_99_00");

        // Ball loss: button ignored until the pause timer has run out
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, o(S_NB, 1, sc), "miss_newball");
        drv(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_NB, 1, sc), "early_btn");
        for (int k = 0; k < 119; k++)
            drv(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, o(S_NB, 1, sc), "nb_wait");
        drv(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, o(S_NB, 1, sc), "nb_tick120");
        drv(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_PL, 1, sc), "nb_relaunch");

        // Hit rise and miss together, then last ball and game over
        sc = (sc + 1) % 100;
        drv(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, o(S_NB, 0, sc), "hit_and_miss");
        for (int k = 0; k < 120; k++)
            drv(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, o(S_NB, 0, sc), "nb2_wait");
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, o(S_NB, 0, sc), "nb2_no_btn");
        drv(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, o(S_PL, 0, sc), "nb2_relaunch");
        pulse(0, "last_ball_hit");
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, o(S_OV, 0, sc), "game_over");
        drv(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, o(S_OV, 0, sc), "over_hit");
        for (int k = 0; k < 119; k++)
            drv(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, o(S_OV, 0, sc), "over_wait");
        drv(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, o(S_OV, 0, sc), "over_tick120");
        sc = 0;
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, o(S_NG, 3, 0), "newgame_entry");

        // Reset in the middle of a NEWBALL pause
        drv(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_PL, 2, 0), "start3");
        for (int k = 0; k < 7; k++) pulse(2, "pulse_to_7");
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, o(S_NB, 1, 7), "miss3");
        for (int k = 0; k < 70; k++)
            drv(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, o(S_NB, 1, 7), "nb3_wait");
        drv(1'b1, 2'b01, 1'b1, 1'b1, 1'b1, o(S_NG, 3, 0), "reset_newball");
        drv(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_PL, 2, 0), "start4");
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, o(S_NB, 1, 0), "miss4");
        drv(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_NB, 1, 0), "no_residual");
        for (int k = 0; k < 120; k++)
            drv(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, o(S_NB, 1, 0), "nb4_wait");
        drv(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, o(S_PL, 1, 0), "nb4_relaunch");
        sc = 0;
        pulse(1, "pre_reset_hit");
        drv(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, o(S_NG, 3, 0), "reset_play");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
